// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MEM-stage access controller for the pipelined LC-3b datapath.
//             Sits between the EX/MEM latch and the dcache. It sequences
//             direct and indirect (LDI/STI) loads and stores, produces lane
//             byte enables and byte-extracted read data, and stalls the
//             pipeline while an access is outstanding. It also handles
//             flush, alignment checking and a dcache response timeout.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             valid_in, rd_req,
//             wr_req, indirect,
//             byte_op, flush      - request qualifiers from the MEM latch
//             address_in,wdata_in - effective address / store data from EX
//             mem_rdata,
//             dcache_resp         - dcache read data and completion
//             mem_address, mem_read, mem_write,
//             mem_wdata, mem_byte_enable - registered dcache request
//             rdata_out, eff_address     - load result / final data address
//             mem_stall, done, fault,
//             fault_cause         - pipeline status
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic                    indirect,
    input  logic                    byte_op,
    input  logic                    flush,
    input  logic [ADDR_WIDTH-1:0]   address_in,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    dcache_resp,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   rdata_out,
    output logic [ADDR_WIDTH-1:0]   eff_address,
    output logic                    mem_stall,
    output logic                    done,
    output logic                    fault,
    output logic [1:0]              fault_cause
);

    localparam int NUM_LANES   = DATA_WIDTH / 8;
    localparam int c_lane_bits = $clog2(NUM_LANES);
    localparam int c_cnt_w     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_limit =
        c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [NUM_LANES-1:0] c_lane0          = NUM_LANES'(1);
    localparam logic [1:0]           c_cause_misalign = 2'b01;
    localparam logic [1:0]           c_cause_timeout  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IND  = 3'd1,
        S_ACC  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                  state_q,  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic                    rd_q,     rd_d;
    logic                    wr_q,     wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [NUM_LANES-1:0]    be_q,     be_d;
    logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    logic [ADDR_WIDTH-1:0]   eff_q,    eff_d;
    logic [1:0]              cause_q,  cause_d;
    logic [c_cnt_w-1:0]      cnt_q,    cnt_d;
    logic                    is_rd_q,  is_rd_d;
    logic                    is_wr_q,  is_wr_d;
    logic                    byte_q,   byte_d;
    // Set for the single strobe-free ACC cycle that follows a pointer fetch;
    // a dcache_resp seen then cannot belong to the data access.
    logic                    issue_q,  issue_d;

    logic                    w_req;
    logic [c_lane_bits-1:0]  w_in_lane;
    logic                    w_in_misaligned;
    logic [ADDR_WIDTH-1:0]   w_ptr;
    logic [c_lane_bits-1:0]  w_ptr_lane;
    logic [DATA_WIDTH-1:0]   w_rd_shift;
    logic [DATA_WIDTH-1:0]   w_rd_byte;
    logic                    w_limit;

    assign w_req           = valid_in & (rd_req | wr_req) & ~flush;
    assign w_in_lane       = address_in[c_lane_bits-1:0];
    // Indirect requests start with a pointer fetch, so only direct word
    // accesses are alignment-checked against address_in.
    assign w_in_misaligned = ~indirect & ~byte_op & (w_in_lane != '0);
    assign w_ptr           = mem_rdata[ADDR_WIDTH-1:0];
    assign w_ptr_lane      = w_ptr[c_lane_bits-1:0];
    assign w_rd_shift      = mem_rdata >> {addr_q[c_lane_bits-1:0], 3'b000};
    assign w_rd_byte       = {{(DATA_WIDTH-8){1'b0}}, w_rd_shift[7:0]};
    assign w_limit         = (TIMEOUT_CYCLES != 0) && (cnt_q == c_cnt_limit);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        eff_d   = eff_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        is_rd_d = is_rd_q;
        is_wr_d = is_wr_q;
        byte_d  = byte_q;
        issue_d = issue_q;

        if (flush) begin
            // Squash wins over everything, including a coincident response.
            state_d = S_IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            issue_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_in_misaligned) begin
                            state_d = S_ERR;
                            cause_d = c_cause_misalign;
                        end else begin
                            // A request with both rd and wr set is a read.
                            is_rd_d = rd_req;
                            is_wr_d = wr_req & ~rd_req;
                            byte_d  = byte_op;
                            wdata_d = byte_op ? {NUM_LANES{wdata_in[7:0]}} : wdata_in;
                            addr_d  = address_in;
                            cnt_d   = '0;
                            issue_d = 1'b0;
                            if (indirect) begin
                                state_d = S_IND;
                                rd_d    = 1'b1;
                                wr_d    = 1'b0;
                                be_d    = '1;
                            end else begin
                                state_d = S_ACC;
                                rd_d    = rd_req;
                                wr_d    = wr_req & ~rd_req;
                                be_d    = byte_op ? (c_lane0 << w_in_lane) : '1;
                            end
                        end
                    end
                end
                S_IND: begin
                    if (dcache_resp) begin
                        rd_d = 1'b0;
                        wr_d = 1'b0;
                        if (!byte_q && (w_ptr_lane != '0)) begin
                            state_d = S_ERR;
                            cause_d = c_cause_misalign;
                        end else begin
                            state_d = S_ACC;
                            addr_d  = w_ptr;
                            be_d    = byte_q ? (c_lane0 << w_ptr_lane) : '1;
                            cnt_d   = '0;
                            issue_d = 1'b1;
                        end
                    end else if (w_limit) begin
                        state_d = S_ERR;
                        cause_d = c_cause_timeout;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + c_cnt_w'(1);
                    end
                end
                S_ACC: begin
                    if (dcache_resp && !issue_q) begin
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        eff_d   = addr_q;
                        state_d = S_DONE;
                        if (is_rd_q) begin
                            rdata_d = byte_q ? w_rd_byte : mem_rdata;
                        end
                    end else if (w_limit) begin
                        // The strobe-free cycle after a pointer fetch counts
                        // toward the timeout like any other wait cycle.
                        state_d = S_ERR;
                        cause_d = c_cause_timeout;
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        issue_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + c_cnt_w'(1);
                        if (issue_q) begin
                            rd_d    = is_rd_q;
                            wr_d    = is_wr_q;
                            issue_d = 1'b0;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            eff_q   <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
            is_rd_q <= 1'b0;
            is_wr_q <= 1'b0;
            byte_q  <= 1'b0;
            issue_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            eff_q   <= eff_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            is_rd_q <= is_rd_d;
            is_wr_q <= is_wr_d;
            byte_q  <= byte_d;
            issue_q <= issue_d;
        end
    end

    assign mem_address     = addr_q;
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;
    assign rdata_out       = rdata_q;
    assign eff_address     = eff_q;
    assign fault_cause     = cause_q;
    assign done            = (state_q == S_DONE) & ~flush;
    assign fault           = (state_q == S_ERR) & ~flush;
    assign mem_stall       = ((state_q == S_IDLE) & w_req & ~w_in_misaligned)
                           | (state_q == S_IND) | (state_q == S_ACC);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Self-checking bench for mem_access_ctrl (32-bit data, 4 lanes,
//             TIMEOUT_CYCLES = 8). Expected dcache requests and completions
//             are queued by an operation-level reference model; a monitor
//             pops and compares them as the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst, valid_in, rd_req, wr_req, indirect, byte_op, flush, dcache_resp;
    logic [AW-1:0] address_in;
    logic [DW-1:0] wdata_in, mem_rdata;
    logic [AW-1:0] mem_address, eff_address;
    logic          mem_read, mem_write, mem_stall, done, fault;
    logic [DW-1:0] mem_wdata, rdata_out;
    logic [3:0]    mem_byte_enable;
    logic [1:0]    fault_cause;

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rd_req(rd_req), .wr_req(wr_req),
        .indirect(indirect), .byte_op(byte_op), .flush(flush), .address_in(address_in),
        .wdata_in(wdata_in), .mem_rdata(mem_rdata), .dcache_resp(dcache_resp),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .rdata_out(rdata_out),
        .eff_address(eff_address), .mem_stall(mem_stall), .done(done), .fault(fault),
        .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        is_fault;
        logic [1:0]  cause;
        logic [31:0] rdata;
        logic [15:0] eff;
    } res_t;

    req_t        exp_req[$];
    res_t        exp_res[$];
    logic [31:0] ovr [int];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = '0;
    logic [15:0] model_eff   = '0;
    logic        resp_on     = 1'b1;
    int          resp_delay  = 0;

    // dcache contents: directed overrides, otherwise a fixed hash of the word address.
    function automatic logic [31:0] rd_word(input logic [15:0] a);
        logic [15:0] w;
        w = {2'b00, a[15:2]};
        if (ovr.exists(int'(w))) return ovr[int'(w)];
        return {16'(w * 16'd40503 + 16'd1), 16'(w * 16'd2654 ^ 16'h3c35)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // dcache responder: answers a strobed request after resp_delay cycles.
    int wait_cnt = 0;
    always @(negedge clk) begin
        dcache_resp = 1'b0;
        mem_rdata   = $urandom;
        if (!rst && resp_on && (mem_read || mem_write)) begin
            if (wait_cnt == resp_delay) begin
                dcache_resp = 1'b1;
                mem_rdata   = rd_word(mem_address);
                wait_cnt    = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor: request issue (strobe rising) and completion (done/fault).
    logic prev_strobe = 1'b0;
    req_t mreq;
    res_t mres;
    always @(negedge clk) begin
        if (rst) begin
            prev_strobe = 1'b0;
        end else begin
            if ((mem_read || mem_write) && !prev_strobe) begin
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_request: addr=0x%0h rd=%0b wr=%0b, required none",
                             mem_address, mem_read, mem_write);
                end else begin
                    mreq = exp_req.pop_front();
                    chk("req_addr", mem_address, mreq.addr);
                    chk("req_read", mem_read, mreq.rd);
                    chk("req_write", mem_write, mreq.wr);
                    chk("req_be", mem_byte_enable, mreq.be);
                    if (mreq.wr) chk("req_wdata", mem_wdata, mreq.wdata);
                end
            end
            prev_strobe = mem_read || mem_write;
            if (done || fault) begin
                if (exp_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_completion: done=%0b fault=%0b, required none", done, fault);
                end else begin
                    mres = exp_res.pop_front();
                    chk("res_fault", fault, mres.is_fault);
                    chk("res_done", done, !mres.is_fault);
                    chk("res_stall_low", mem_stall, 0);
                    if (mres.is_fault) begin
                        chk("fault_cause", fault_cause, mres.cause);
                    end else begin
                        chk("rdata_out", rdata_out, mres.rdata);
                        chk("eff_address", eff_address, mres.eff);
                    end
                end
            end
        end
    end

    // One MEM-stage operation: predict, drive, wait for completion, check stall length.
    task automatic run_op(input logic ind, input logic rd, input logic wr, input logic byt,
                          input logic [15:0] addr, input logic [31:0] wd, input int d,
                          input logic respond);
        logic        is_rd, is_wr, ended;
        logic [15:0] fin;
        logic [31:0] w;
        int          exp_stall, stall;
        req_t        r;
        res_t        s;
        is_rd      = rd;
        is_wr      = wr & ~rd;
        s.is_fault = 1'b0;
        s.cause    = 2'b00;
        s.rdata    = model_rdata;
        s.eff      = model_eff;
        if (!ind && !byt && addr[1:0] != 2'b00) begin
            s.is_fault = 1'b1;
            s.cause    = 2'b01;
            exp_stall  = 0;
        end else begin
            fin       = addr;
            exp_stall = 1;
            if (ind) begin
                r.addr = addr; r.rd = 1'b1; r.wr = 1'b0; r.be = 4'hF; r.wdata = '0;
                exp_req.push_back(r);
                w         = rd_word(addr);
                fin       = w[15:0];
                exp_stall += d + 1;
            end
            if (ind && !byt && fin[1:0] != 2'b00) begin
                s.is_fault = 1'b1;
                s.cause    = 2'b01;
            end else begin
                r.addr  = fin;
                r.rd    = is_rd;
                r.wr    = is_wr;
                r.be    = byt ? (4'b0001 << fin[1:0]) : 4'hF;
                r.wdata = byt ? {4{wd[7:0]}} : wd;
                exp_req.push_back(r);
                exp_stall += (ind ? 1 : 0) + (respond ? d + 1 : TO);
                if (!respond) begin
                    s.is_fault = 1'b1;
                    s.cause    = 2'b10;
                end else begin
                    w = rd_word(fin);
                    if (is_rd) s.rdata = byt ? ((w >> (8 * fin[1:0])) & 32'hFF) : w;
                    s.eff       = fin;
                    model_rdata = s.rdata;
                    model_eff   = s.eff;
                end
            end
        end
        exp_res.push_back(s);

        @(posedge clk); #1;
        valid_in = 1'b1; rd_req = rd; wr_req = wr; indirect = ind; byte_op = byt;
        address_in = addr; wdata_in = wd; resp_on = respond; resp_delay = d;
        ended = 1'b0;
        stall = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done || fault) begin
                ended = 1'b1;
                break;
            end
            if (mem_stall) stall++;
        end
        if (!ended) begin
            chk("op_completes", ended, 1);
            finish_all();
        end
        chk("stall_cycles", stall, exp_stall);
        @(posedge clk); #1;
        valid_in = 1'b0; resp_on = 1'b1;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rw;
        logic        ind, byt, respond;
        logic [15:0] addr;
        req_t        r;

        rst = 1'b1; valid_in = 1'b0; rd_req = 1'b0; wr_req = 1'b0; indirect = 1'b0;
        byte_op = 1'b0; flush = 1'b0; address_in = '0; wdata_in = '0;
        dcache_resp = 1'b0; mem_rdata = '0;
        ovr[int'(16'h1000 >> 2)] = 32'h0000BEEF;
        ovr[int'(16'h3000 >> 2)] = 32'h00004004;
        ovr[int'(16'h4004 >> 2)] = 32'h00001234;
        ovr[int'(16'h5003 >> 2)] = 32'hAABBCCDD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_be", mem_byte_enable, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata_out", rdata_out, 0);
        chk("rst_eff_address", eff_address, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_cause", fault_cause, 0);
        chk("rst_stall", mem_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed operations.
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 32'h0, 1, 1'b1);          // LDR, resp after 2
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 16'h2001, 32'h000000A5, 2, 1'b1);   // STB
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h3000, 32'h0, 0, 1'b1);          // LDI
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h1001, 32'h0, 0, 1'b1);          // misaligned LDR
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 32'h0, 0, 1'b0);          // timeout
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h5003, 32'h0, 0, 1'b1);          // LDB lane 3
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h1000, 32'hFFFF0000, 0, 1'b1);   // rd+wr -> read

        // Flush in ACC: access abandoned, no completion of any kind.
        r.addr = 16'h1000; r.rd = 1'b1; r.wr = 1'b0; r.be = 4'hF; r.wdata = '0;
        exp_req.push_back(r);
        @(posedge clk); #1;
        valid_in = 1'b1; rd_req = 1'b1; wr_req = 1'b0; indirect = 1'b0; byte_op = 1'b0;
        address_in = 16'h1000; resp_on = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_pre_stall", mem_stall, 1);
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_no_done", done, 0);
        chk("flush_no_fault", fault, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_read_low", mem_read, 0);
        chk("flush_stall_low", mem_stall, 0);
        repeat (12) @(negedge clk);
        resp_on = 1'b1;

        // Randomized operations.
        for (int k = 0; k < 70; k++) begin
            rw   = 2'($urandom_range(1, 3));
            ind  = ($urandom_range(0, 3) == 0);
            byt  = 1'($urandom_range(0, 1));
            addr = 16'($urandom);
            if (ind || (!byt && $urandom_range(0, 2) != 0)) addr[1:0] = 2'b00;
            respond = ind ? 1'b1 : ($urandom_range(0, 9) != 0);
            run_op(ind, rw[1], rw[0], byt, addr, 32'($urandom), int'($urandom_range(0, 3)), respond);
        end

        // Reset in the middle of an access clears every register.
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h1001, 32'h0, 0, 1'b1);
        r.addr = 16'h2000; r.rd = 1'b1; r.wr = 1'b0; r.be = 4'hF; r.wdata = '0;
        exp_req.push_back(r);
        @(posedge clk); #1;
        valid_in = 1'b1; rd_req = 1'b1; wr_req = 1'b0; indirect = 1'b0; byte_op = 1'b0;
        address_in = 16'h2000; resp_on = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; resp_on = 1'b1;
        model_rdata = '0;
        model_eff   = '0;
        @(negedge clk);
        chk("midrst_fault_cause", fault_cause, 0);
        chk("midrst_rdata_out", rdata_out, 0);
        chk("midrst_eff_address", eff_address, 0);
        chk("midrst_mem_read", mem_read, 0);
        chk("midrst_mem_address", mem_address, 0);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000, 32'h0, 1, 1'b1);

        repeat (3) @(negedge clk);
        chk("req_queue_drained", exp_req.size(), 0);
        chk("res_queue_drained", exp_res.size(), 0);
        finish_all();
    end

endmodule
`default_nettype wire
